// File: rtl/zjh_logic_pkg.sv
// zjh_logic_pkg: shared default counter width and the two decision functions.
`default_nettype none

package zjh_logic_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Lift passes when the chief referee and at least one side referee approve.
  function automatic logic f_cp(input logic a, input logic b, input logic c);
    return a & (b | c);
  endfunction

  // Lamp fault unless exactly one lamp is lit.
  function automatic logic f_jtd(input logic a, input logic b, input logic c);
    return ~(a ^ b ^ c) | (a & b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/zjh_cp.sv
// zjh_cp: weightlifting-referee pass decision.
`default_nettype none

module zjh_cp
  import zjh_logic_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic pass
);

  assign pass = f_cp(a, b, c);

endmodule

`default_nettype wire

// File: rtl/zjh_gate6.sv
// zjh_gate6: the six basic two-input gate functions, purely combinational.
`default_nettype none

module zjh_gate6 (
  input  logic a,
  input  logic b,
  output logic g_and,
  output logic g_or,
  output logic g_nand,
  output logic g_nor,
  output logic g_xor,
  output logic g_xnor
);

  assign g_and  = a & b;
  assign g_or   = a | b;
  assign g_nand = ~(a & b);
  assign g_nor  = ~(a | b);
  assign g_xor  = a ^ b;
  assign g_xnor = ~(a ^ b);

endmodule

`default_nettype wire

// File: rtl/zjh_jtd.sv
// zjh_jtd: traffic-light fault detector.
`default_nettype none

module zjh_jtd
  import zjh_logic_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic fault
);

  assign fault = f_jtd(a, b, c);

endmodule

`default_nettype wire

// File: rtl/zjh_bas_gate.sv
// zjh_bas_gate: registered gate/decision outputs plus a saturating fault counter.
`default_nettype none

module zjh_bas_gate
  import zjh_logic_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             y4,
  output logic             y5,
  output logic             y6,
  output logic             y_cp,
  output logic             y_jtd,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic g_and, g_or, g_nand, g_nor, g_xor, g_xnor;
  logic cp_comb, jtd_comb;

  zjh_gate6 u_gate6 (
    .a      (a),
    .b      (b),
    .g_and  (g_and),
    .g_or   (g_or),
    .g_nand (g_nand),
    .g_nor  (g_nor),
    .g_xor  (g_xor),
    .g_xnor (g_xnor)
  );

  zjh_cp u_cp (
    .a    (a),
    .b    (b),
    .c    (c),
    .pass (cp_comb)
  );

  zjh_jtd u_jtd (
    .a     (a),
    .b     (b),
    .c     (c),
    .fault (jtd_comb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y1        <= 1'b0;
      y2        <= 1'b0;
      y3        <= 1'b0;
      y4        <= 1'b0;
      y5        <= 1'b0;
      y6        <= 1'b0;
      y_cp      <= 1'b0;
      y_jtd     <= 1'b0;
      fault_cnt <= '0;
    end else begin
      y1    <= g_and;
      y2    <= g_or;
      y3    <= g_nand;
      y4    <= g_nor;
      y5    <= g_xor;
      y6    <= g_xnor;
      y_cp  <= cp_comb;
      y_jtd <= jtd_comb;
      // Counts the registered flag, so the count trails y_jtd by one cycle.
      if (y_jtd && (fault_cnt != CNT_MAX)) begin
        fault_cnt <= fault_cnt + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zjh_bas_gate.sv
// tb_zjh_bas_gate: directed self-checking bench for zjh_bas_gate (CNT_W = 4).
`default_nettype none

module tb_zjh_bas_gate;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b1, b = 1'b1, c = 1'b1;
  logic       y1, y2, y3, y4, y5, y6, y_cp, y_jtd;
  logic [3:0] fault_cnt;

  int passes = 0;
  int total  = 0;

  // Hand-derived truth tables indexed by {a,b,c}.
  logic [7:0] jtd_tab = 8'b1110_1001;
  logic [7:0] cp_tab  = 8'b1110_0000;
  logic [2:0] cp_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b100, 3'b101, 3'b111};

  logic       exp_jtd = 1'b0;
  int         exp_cnt = 0;

  always #5 clk = ~clk;

  zjh_bas_gate #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5),
    .y6        (y6),
    .y_cp      (y_cp),
    .y_jtd     (y_jtd),
    .fault_cnt (fault_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // One clock; the expected counter follows the previously registered fault flag.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_cnt = 0;
      exp_jtd = 1'b0;
    end else begin
      if (exp_jtd && exp_cnt != 15) exp_cnt++;
      exp_jtd = jtd_tab[{a, b, c}];
    end
    #1;
  endtask

  initial begin
    logic [5:0] gexp [4] = '{6'b001101, 6'b011010, 6'b110001, 6'b011010};
    logic [1:0] gab  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Reset with all inputs high.
    rst = 1'b1; a = 1'b1; b = 1'b1; c = 1'b1;
    tick(); tick();
    check("reset_gates", {y1, y2, y3, y4, y5, y6}, 6'b000000);
    check("reset_cp", y_cp, 1'b0);
    check("reset_jtd", y_jtd, 1'b0);
    check("reset_cnt", fault_cnt, 0);

    // Gate sweep, c held low.
    rst = 1'b0; c = 1'b0;
    for (int p = 0; p < 4; p++) begin
      {a, b} = gab[p];
      tick();
      check($sformatf("gates_%02b", gab[p]), {y1, y2, y3, y4, y5, y6}, gexp[p]);
      if (p == 0) check("first_edge_cnt", fault_cnt, 0);
      for (int k = 1; k < 10; k++) tick();
      check($sformatf("sweep_cnt_%0d", p), fault_cnt, exp_cnt);
    end

    // Clear, then the decision-function sequence.
    rst = 1'b1; tick(); rst = 1'b0;
    check("clear_cnt", fault_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = cp_seq[i];
      tick();
      check($sformatf("cp_%03b", cp_seq[i]), y_cp, cp_tab[cp_seq[i]]);
      check($sformatf("jtd_%03b", cp_seq[i]), y_jtd, jtd_tab[cp_seq[i]]);
      check($sformatf("seq_cnt_%0d", i), fault_cnt, exp_cnt);
    end
    tick();
    check("seq_cnt_final", fault_cnt, 5);

    // Saturation: 20 cycles of all-off lamps.
    {a, b, c} = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), fault_cnt, exp_cnt);
    end
    check("sat_hold", fault_cnt, 15);

    // Mid-run reset at a count of 7.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pre_reset_cnt", fault_cnt, 7);
    rst = 1'b1; {a, b, c} = 3'b111;
    tick();
    check("midrst_cnt", fault_cnt, 0);
    check("midrst_jtd", y_jtd, 1'b0);
    check("midrst_gates", {y1, y2, y3, y4, y5, y6}, 6'b000000);
    rst = 1'b0;
    tick();
    check("resume_jtd", y_jtd, 1'b1);
    check("resume_cnt0", fault_cnt, 0);
    tick();
    check("resume_cnt1", fault_cnt, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
